// File: rtl/multi_div_gen_if.sv
// +----------------------------------------------------------------------------+
// | multi_div_gen_if : control/output bundle for the multi-channel divider.    |
// | Optional ph_val port present when MULTI_DIV_GEN_PHASE_EN is defined.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface multi_div_gen_if #(
  parameter int NCH   = 4,
  parameter int DIV_W = 8
);
  logic [NCH-1:0]       ch_en;
  logic [NCH-1:0]       mode;
  logic [NCH*DIV_W-1:0] div_val;
  logic [NCH-1:0]       div_load;
  logic                 sync;
`ifdef MULTI_DIV_GEN_PHASE_EN
  logic [NCH*DIV_W-1:0] ph_val;
`endif
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       wave;
  logic [NCH-1:0]       pend;

  modport master (
    output ch_en, mode, div_val, div_load, sync,
`ifdef MULTI_DIV_GEN_PHASE_EN
    output ph_val,
`endif
    input  tick, wave, pend
  );

  modport slave (
    input  ch_en, mode, div_val, div_load, sync,
`ifdef MULTI_DIV_GEN_PHASE_EN
    input  ph_val,
`endif
    output tick, wave, pend
  );
endinterface

`default_nettype wire

// File: rtl/multi_div_gen.sv
// +----------------------------------------------------------------------------+
// | multi_div_gen : NCH independent programmable dividers with glitch-free     |
// | ratio updates, pulse/square outputs and a shared sync restart.             |
// | Optional macro MULTI_DIV_GEN_PHASE_EN adds per-channel sync phase offset.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module multi_div_gen #(
  parameter int NCH     = 4,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 49
) (
  input  wire logic      sys_clk,
  input  wire logic      sys_rst,
  multi_div_gen_if.slave bus
);

  localparam logic [DIV_W-1:0] C_DIV_RST = DIV_W'(DIV_RST);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] r_act;
    logic [DIV_W-1:0] r_shd;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_tick;
    logic             r_wave;

    logic [DIV_W-1:0] w_ld_val;
    logic             w_wrap;
    logic             w_bound;
    logic [DIV_W-1:0] w_act_n;
    logic [DIV_W-1:0] w_cnt_n;
    logic [DIV_W:0]   w_half;

    assign w_ld_val = bus.div_val[i*DIV_W +: DIV_W];
    assign w_wrap   = (r_cnt == r_act);
    assign w_bound  = bus.sync | w_wrap;

    // A new ratio only ever reaches r_act at a period boundary (sync or wrap).
    always_comb begin
      w_act_n = r_act;
      if (w_bound) begin
        if (bus.div_load[i]) begin
          w_act_n = w_ld_val;
        end else if (r_pend) begin
          w_act_n = r_shd;
        end
      end
    end

`ifdef MULTI_DIV_GEN_PHASE_EN
    logic [DIV_W-1:0] w_ph;
    assign w_ph = bus.ph_val[i*DIV_W +: DIV_W];
`endif

    always_comb begin
      w_cnt_n = r_cnt + DIV_W'(1);
      if (bus.sync) begin
`ifdef MULTI_DIV_GEN_PHASE_EN
        w_cnt_n = (w_ph <= w_act_n) ? w_ph : '0;
`else
        w_cnt_n = '0;
`endif
      end else if (w_wrap) begin
        w_cnt_n = '0;
      end
    end

    // ceil(R/2) with R = act + 1 equals floor(act/2) + 1; one extra bit avoids overflow.
    assign w_half = (DIV_W+1)'(w_act_n >> 1) + (DIV_W+1)'(1);

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_act  <= C_DIV_RST;
        r_shd  <= C_DIV_RST;
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_tick <= 1'b0;
        r_wave <= 1'b0;
      end else if (!bus.ch_en[i]) begin
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_tick <= 1'b0;
        r_wave <= 1'b0;
        if (bus.div_load[i]) begin
          r_act <= w_ld_val;
        end
      end else begin
        r_act <= w_act_n;
        r_cnt <= w_cnt_n;
        if (w_bound) begin
          r_pend <= 1'b0;
        end else if (bus.div_load[i]) begin
          r_shd  <= w_ld_val;
          r_pend <= 1'b1;
        end
        r_tick <= (w_cnt_n == '0);
        r_wave <= bus.mode[i] ? ({1'b0, w_cnt_n} < w_half) : (w_cnt_n == '0);
      end
    end

    assign bus.tick[i] = r_tick;
    assign bus.wave[i] = r_wave;
    assign bus.pend[i] = r_pend;
  end

endmodule

`default_nettype wire

// File: doc/multi_div_gen.md
Name: multi_div_gen

Overview:
- Parametrised multi-channel clock-enable and divider generator: the successor to the fixed one-hot ring divider.
- NCH independent channels share one clock. Each channel has a runtime-programmable divide ratio and a pulse or square output mode.
- Ratio updates are glitch-free: a new ratio takes effect only at a period boundary. A global sync input phase-aligns all channels.
- Sits next to the board clock. Feeds tick enables to timers/UART/LED logic and square waves to GPIO.

Parameters:
- NCH, 4, number of divider channels (1..16).
- DIV_W, 8, ratio field width; ratio R = div_val + 1, range 1..2^DIV_W.
- DIV_RST, 49, div_val value loaded at reset (R = 50, i.e. 1 MHz tick from 50 MHz).

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- ch_en    input  NCH  per-channel enable.
- mode     input  NCH  per-channel mode: 0 = pulse, 1 = square.
- div_val  input  NCH*DIV_W  per-channel ratio minus one; channel i uses bits [i*DIV_W +: DIV_W].
- div_load input  NCH  per-channel single-cycle strobe; captures div_val.
- sync     input  1  global restart strobe.
- tick     output NCH  registered; one-cycle pulse per period.
- wave     output NCH  registered; pulse or square output depending on mode.
- pend     output NCH  registered; 1 = a loaded ratio is waiting for the period boundary.

Behaviour:
- Per-channel state:
  - act: active ratio field, DIV_W bits.
  - shd: shadow ratio field, DIV_W bits.
  - cnt: counter, DIV_W bits.
  - pend: pending flag.
- Derived values:
  - R = act + 1.
  - H = (R + 1) >> 1, i.e. ceil(R/2), computed at DIV_W+1 bits; no overflow at R = 2^DIV_W.
- Reset (priority over everything): cnt = 0, act = shd = DIV_RST, pend = 0, tick = 0, wave = 0, all channels.
- Disabled channel (ch_en = 0):
  - cnt <= 0, tick <= 0, wave <= 0.
  - div_load writes act directly; pend <= 0.
  - sync is ignored.
- Enabled channel, evaluated per edge in priority order:
  1. sync = 1:
     - cnt_n = 0.
     - If div_load: act <= div_val.
     - Else if pend: act <= shd.
     - pend <= 0.
  2. Wrap (cnt == act):
     - cnt_n = 0.
     - If div_load: act <= div_val.
     - Else if pend: act <= shd.
     - pend <= 0.
  3. Otherwise:
     - cnt_n = cnt + 1.
     - If div_load: shd <= div_val and pend <= 1; a later load before the boundary overwrites shd.
- Outputs, registered from the post-edge state (cnt_n, new act):
  - tick <= (cnt_n == 0).
  - Mode 0: wave <= tick value.
  - Mode 1: wave <= (cnt_n < H).
- Resulting timing:
  - Period is R cycles. tick is high in exactly 1 of every R cycles.
  - In square mode, wave is high for ceil(R/2) cycles and low for floor(R/2) cycles.
  - R = 1: cnt stays 0; tick and wave are constantly 1 while enabled.
- Enable latency: the first edge with ch_en = 1 moves cnt from 0 to 1 (R > 1). The first tick appears R edges after enable.
- Mode changes take effect on the next edge; cnt is not disturbed.
- Channels are fully independent except for the shared sync.

Optional Feature:
- Macro: MULTI_DIV_GEN_PHASE_EN.
- Defined:
  - Adds input ph_val, NCH*DIV_W, per-channel phase offset.
  - On sync, cnt_n = ph_val if ph_val <= new act, else 0.
  - tick and wave then follow the normal rules, so tick is 1 after sync only when cnt_n == 0.
  - Allows quadrature or staggered channels.
- Not defined:
  - No ph_val port; sync always sets cnt_n = 0.

Test Plan:
1. Reset release with ch_en = 4'b0001, no loads -> ch0 tick high every 50 cycles, first tick 50 edges after enable; wave identical to tick; ch1..3 outputs 0.
2. ch0 div_val = 4 (R = 5), load while disabled, then enable, mode = 1 -> wave pattern 1,1,1,0,0 repeating; tick once per 5 cycles.
3. ch0 running R = 10, load div_val = 2 at cnt = 3 -> pend = 1 until wrap; old period of 10 completes; next periods are 3 cycles; pend drops on the wrap edge.
4. Load coincident with the wrap edge, and two loads within one period -> new/latest value applied at the boundary; no short or long glitch period.
5. Four channels at R = 3, 4, 5, 7 with sync pulsed mid-run -> all ticks high on the cycle after sync; periods are correct afterwards; disabled channels stay 0.
6. sys_rst asserted mid-period with pend = 1 -> next cycle: all outputs 0, pend = 0, act = 49; with the macro, ph_val = 2, R = 4, sync -> ticks land 2 cycles after sync.
